// File: rtl/multicycle_control_fsm.sv
// Sequencing controller for the multi-cycle RV32I core.
// Steps fetch/decode/execute/memory/writeback and guards memory waits with a timeout.
module multicycle_control_fsm #(
    parameter int MEM_TIMEOUT = 64,
    parameter int CNT_W       = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             run,
    output logic             imem_req,
    input  logic             imem_ready,
    output logic             ir_load,
    input  logic [1:0]       dec_rd_select,
    input  logic             dec_rf_write_en,
    input  logic             dec_mem_write_en,
    input  logic             branch_taken,
    output logic             dmem_req,
    output logic             dmem_we,
    input  logic             dmem_ready,
    output logic             pc_write_en,
    output logic             pc_src,
    output logic             rf_write_strobe,
    output logic [2:0]       state,
    output logic [CNT_W-1:0] instret,
    output logic             fault
);

    localparam int WAIT_W = (MEM_TIMEOUT > 2) ? $clog2(MEM_TIMEOUT) : 1;
    localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(MEM_TIMEOUT - 1);

    typedef enum logic [2:0] {
        S_IDLE      = 3'd0,
        S_FETCH     = 3'd1,
        S_DECODE    = 3'd2,
        S_EXECUTE   = 3'd3,
        S_MEMORY    = 3'd4,
        S_WRITEBACK = 3'd5,
        S_FAULT     = 3'd6
    } state_t;

    state_t            state_q;
    state_t            state_d;
    logic [WAIT_W-1:0] wait_cnt;
    logic              taken_q;
    logic              is_mem;
    logic              waiting;
    logic              timed_out;

    // A load is recognised by its writeback source being the memory port.
    assign is_mem    = dec_mem_write_en
                     | (dec_rf_write_en & (dec_rd_select == 2'd1));
    assign waiting   = ((state_q == S_FETCH)  & ~imem_ready)
                     | ((state_q == S_MEMORY) & ~dmem_ready);
    assign timed_out = (wait_cnt == WAIT_LAST);
    assign state     = state_q;

    // State register.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state and output decode; ready on the last wait cycle beats timeout.
    always_comb begin
        state_d         = state_q;
        imem_req        = 1'b0;
        ir_load         = 1'b0;
        dmem_req        = 1'b0;
        dmem_we         = 1'b0;
        pc_write_en     = 1'b0;
        pc_src          = 1'b0;
        rf_write_strobe = 1'b0;
        fault           = 1'b0;
        unique case (state_q)
            S_IDLE: begin
                if (run) begin
                    state_d = S_FETCH;
                end
            end
            S_FETCH: begin
                imem_req = 1'b1;
                ir_load  = imem_ready;
                if (imem_ready) begin
                    state_d = S_DECODE;
                end else if (timed_out) begin
                    state_d = S_FAULT;
                end
            end
            S_DECODE: begin
                state_d = S_EXECUTE;
            end
            S_EXECUTE: begin
                state_d = is_mem ? S_MEMORY : S_WRITEBACK;
            end
            S_MEMORY: begin
                dmem_req = 1'b1;
                dmem_we  = dec_mem_write_en;
                if (dmem_ready) begin
                    state_d = S_WRITEBACK;
                end else if (timed_out) begin
                    state_d = S_FAULT;
                end
            end
            S_WRITEBACK: begin
                pc_write_en     = 1'b1;
                pc_src          = taken_q;
                rf_write_strobe = dec_rf_write_en;
                state_d         = run ? S_FETCH : S_IDLE;
            end
            S_FAULT: begin
                fault = 1'b1;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // Wait counter: cleared on any state change, so every FETCH/MEMORY entry starts at 0.
    always_ff @(posedge clk) begin
        if (reset) begin
            wait_cnt <= '0;
        end else if (state_d != state_q) begin
            wait_cnt <= '0;
        end else if (waiting) begin
            wait_cnt <= wait_cnt + WAIT_W'(1);
        end
    end

    // Branch decision is only valid in EXECUTE, so hold it for WRITEBACK.
    always_ff @(posedge clk) begin
        if (reset) begin
            taken_q <= 1'b0;
        end else if (state_q == S_EXECUTE) begin
            taken_q <= branch_taken;
        end
    end

    // Retired-instruction counter, wraps naturally.
    always_ff @(posedge clk) begin
        if (reset) begin
            instret <= '0;
        end else if (state_q == S_WRITEBACK) begin
            instret <= instret + CNT_W'(1);
        end
    end

endmodule

// File: doc/multicycle_control_fsm.md
Name: multicycle_control_fsm

Overview:
- Sequencing controller for the multi-cycle RV32I core.
- Steps each instruction through fetch, decode, execute, memory and writeback using the instruction-decode outputs and the branch-module decision.
- Drives PC, instruction-register, register-file and data-memory enables; handshakes with instruction and data memory.
- Keeps a retired-instruction counter and a sticky memory-timeout fault.

Parameters:
MEM_TIMEOUT, 64, max consecutive cycles a memory request may wait for ready before fault (>=2)
CNT_W, 32, width of retired-instruction counter

Ports:
clk  input  1  core clock; all state changes on rising edge
reset  input  1  synchronous, active-high reset
run  input  1  permit fetching new instructions
imem_req  output  1  instruction fetch request
imem_ready  input  1  instruction word valid this cycle
ir_load  output  1  load instruction register
dec_rd_select  input  2  decoder writeback source (1 = memory/load)
dec_rf_write_en  input  1  decoder register-file write enable
dec_mem_write_en  input  1  decoder store indication
branch_taken  input  1  branch-module redirect decision, valid in EXECUTE
dmem_req  output  1  data memory request
dmem_we  output  1  data memory write (store)
dmem_ready  input  1  data access complete this cycle
pc_write_en  output  1  update PC
pc_src  output  1  0 = PC+4, 1 = branch/jump target
rf_write_strobe  output  1  commit register-file write
state  output  3  current state encoding
instret  output  CNT_W  retired-instruction count
fault  output  1  sticky memory-timeout fault

Behaviour:
- Reset (synchronous):
  - Edge with reset=1 gives state=IDLE, instret=0, wait counter=0, taken_q=0, fault=0.
  - All outputs are 0 while in IDLE.
  - Reset mid-instruction aborts the instruction: no PC or RF write, request dropped after that edge.
- State encoding: IDLE=0, FETCH=1, DECODE=2, EXECUTE=3, MEMORY=4, WRITEBACK=5, FAULT=6.
- IDLE: run=1 -> FETCH, else stay.
- FETCH:
  - imem_req=1.
  - imem_ready=1: ir_load=1 in the same cycle (combinational), -> DECODE.
- DECODE: one cycle for register-file read, -> EXECUTE.
- EXECUTE:
  - Register taken_q <= branch_taken.
  - is_mem = dec_mem_write_en | (dec_rf_write_en & dec_rd_select==1).
  - is_mem -> MEMORY, else -> WRITEBACK.
- MEMORY:
  - dmem_req=1, dmem_we=dec_mem_write_en.
  - dmem_ready=1 -> WRITEBACK.
- WRITEBACK:
  - pc_write_en=1, pc_src=taken_q, rf_write_strobe=dec_rf_write_en.
  - instret increments by 1, wrapping at 2^CNT_W to 0.
  - Next state: run=1 -> FETCH, else IDLE.
  - run is sampled only here and in IDLE; deasserting it mid-instruction completes the instruction.
- Timeout:
  - Wait counter clears on entry to FETCH or MEMORY.
  - Increments each FETCH/MEMORY cycle with ready=0.
  - Ready=0 while counter==MEM_TIMEOUT-1 (the MEM_TIMEOUT-th request cycle) -> FAULT.
  - Ready=1 in that same cycle wins: normal transition.
- FAULT: all request/enable outputs 0, fault=1; leave only via reset.
- Latency:
  - Non-memory instruction with zero-wait imem: 4 cycles.
  - Load/store with zero-wait memories: 5 cycles.
  - Each ready wait adds 1 cycle.
- Outputs are Moore decodes of state, except ir_load, which also needs imem_ready=1.

Test Plan:
- ALU op: reset, run=1, imem_ready=1 always, dec_rf_write_en=1, rd_select=0 -> states 1,2,3,5; rf_write_strobe=1 and pc_write_en=1 on cycle 4; instret=1.
- Load with dmem_ready delayed 3 cycles: dmem_req high 4 cycles, dmem_we=0, then WRITEBACK with strobe; total 8 cycles; instret=1.
- Store plus taken branch: dec_mem_write_en=1 -> dmem_we=1, rf_write_strobe=0. Separately, branch_taken=1 in EXECUTE then 0 -> pc_src=1 in WRITEBACK.
- Timeout, MEM_TIMEOUT=4: imem_ready=0 forever -> FAULT after 4 FETCH cycles, fault=1 sticky. Ready on exactly the 4th cycle -> DECODE, no fault.
- run drop and reset: deassert run in DECODE -> instruction retires, then IDLE. Assert reset during MEMORY -> IDLE next cycle, no strobe, instret unchanged.
- Wrap: CNT_W=4, retire 16 instructions -> instret returns to 0.
